// File: rtl/tristate_bus_pkg.sv
// Shared definitions for the tri-state bus port: FSM state codes, bus direction codes
// and the turnaround counter width.
package tristate_bus_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TURN  = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        TURN  = ST_TURN,
        DRIVE = ST_DRIVE,
        WAIT  = ST_WAIT
    } state_t;

    localparam logic DIR_RX = 1'b0;
    localparam logic DIR_TX = 1'b1;

endpackage

// File: rtl/tristate_bus_cnt.sv
// Loadable down-counter with a zero flag, used for bus turnaround and read timeout.
// A load takes priority over a decrement, and the count saturates at zero.
module tristate_bus_cnt
    import tristate_bus_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic         i_dec,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/tristate_bus_port.sv
// Half-duplex endpoint that owns the output enable of a shared tri-state data bus.
// Optional read timeout is enabled with `define TRISTATE_BUS_TIMEOUT_EN.
module tristate_bus_port
    import tristate_bus_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int TURN_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             rx_req,
    output logic             rx_ready,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_err,
    inout  wire  [WIDTH-1:0] bus_data,
    output logic             bus_oe,
    output logic             bus_strobe,
    input  logic             bus_ack
);

    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

    state_t           r_state;
    logic             r_dir;
    logic [WIDTH-1:0] r_drv;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_oe;
    logic             r_strobe;
    logic             r_rx_valid;

    logic w_wr_acc;
    logic w_rd_acc;
    logic w_turn_load;
    logic w_turn_zero;

    assign tx_ready = (r_state == IDLE);
    assign rx_ready = (r_state == IDLE) && !tx_valid;
    assign w_wr_acc = tx_valid && tx_ready;
    assign w_rd_acc = rx_req && rx_ready;

    // The turnaround is paid only when the requested direction differs from the parked one.
    assign w_turn_load = (w_wr_acc && (r_dir == DIR_RX)) ||
                         (w_rd_acc && (r_dir == DIR_TX));

    tristate_bus_cnt #(.W(CNT_W)) u_turn_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_turn_load),
        .i_dec      (r_state == TURN),
        .i_load_val (TURN_LOAD),
        .o_zero     (w_turn_zero)
    );

`ifdef TRISTATE_BUS_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic r_rx_err;
    logic w_to_load;
    logic w_to_zero;

    assign w_to_load = (w_rd_acc && (r_dir == DIR_RX)) ||
                       ((r_state == TURN) && w_turn_zero && (r_dir == DIR_TX));

    tristate_bus_cnt #(.W(TO_W)) u_to_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_to_load),
        .i_dec      (r_state == WAIT),
        .i_load_val (TO_LOAD),
        .o_zero     (w_to_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_err <= 1'b0;
        end else begin
            r_rx_err <= (r_state == WAIT) && !bus_ack && w_to_zero;
        end
    end

    assign rx_err = r_rx_err;
`else
    assign rx_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_dir      <= DIR_RX;
            r_drv      <= '0;
            r_rx_data  <= '0;
            r_oe       <= 1'b0;
            r_strobe   <= 1'b0;
            r_rx_valid <= 1'b0;
        end else begin
            r_strobe   <= 1'b0;
            r_rx_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_wr_acc) begin
                        r_drv <= tx_data;
                        if (r_dir == DIR_TX) begin
                            r_state  <= DRIVE;
                            r_oe     <= 1'b1;
                            r_strobe <= 1'b1;
                        end else begin
                            r_state <= TURN;
                        end
                    end else if (w_rd_acc) begin
                        r_oe <= 1'b0;
                        r_state <= (r_dir == DIR_TX) ? TURN : WAIT;
                    end
                end
                // r_dir still holds the old direction here, which tells us where to go next.
                TURN: begin
                    if (w_turn_zero) begin
                        if (r_dir == DIR_RX) begin
                            r_state  <= DRIVE;
                            r_oe     <= 1'b1;
                            r_strobe <= 1'b1;
                            r_dir    <= DIR_TX;
                        end else begin
                            r_state <= WAIT;
                            r_dir   <= DIR_RX;
                        end
                    end
                end
                DRIVE: begin
                    r_state <= IDLE;
                end
                WAIT: begin
                    if (bus_ack) begin
                        r_rx_data  <= bus_data;
                        r_rx_valid <= 1'b1;
                        r_state    <= IDLE;
                        r_dir      <= DIR_RX;
`ifdef TRISTATE_BUS_TIMEOUT_EN
                    end else if (w_to_zero) begin
                        r_state <= IDLE;
                        r_dir   <= DIR_RX;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus_data   = r_oe ? r_drv : {WIDTH{1'bz}};
    assign bus_oe     = r_oe;
    assign bus_strobe = r_strobe;
    assign rx_valid   = r_rx_valid;
    assign rx_data    = r_rx_data;

endmodule

// File: tb/tb_tristate_bus_port.sv
// Self-checking bench for tristate_bus_port: a scoreboard queues expected strobe and read data,
// while the driver checks cycle timing of turnaround, strobes, handshakes and reset.
module tb_tristate_bus_port;

   localparam int W       = 8;
   localparam int TURN    = 1;
   localparam int TIMEOUT = 16;

   logic clock = 1'b0;
   logic resetN;
   logic txValid;
   logic txReady;
   logic [W-1:0] txData;
   logic rxReq;
   logic rxReady;
   logic rxValid;
   logic [W-1:0] rxData;
   logic rxErr;
   logic busOe;
   logic busStrobe;
   logic busAck;
   logic peerOe;
   logic [W-1:0] peerData;
   wire  [W-1:0] busData;

   int checkCount = 0;
   int errCount = 0;
   int cyc = 0;
   logic [W-1:0] wrQ[$];
   logic [W-1:0] rdQ[$];
   logic [W-1:0] monExp;
   logic [W-1:0] lastRx;
   bit expDir;
   int strobeCyc;

   assign busData = peerOe ? peerData : {W{1'bz}};

   tristate_bus_port #(.WIDTH(W), .TURN_CYCLES(TURN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clock), .reset_n(resetN),
      .tx_valid(txValid), .tx_ready(txReady), .tx_data(txData),
      .rx_req(rxReq), .rx_ready(rxReady), .rx_valid(rxValid), .rx_data(rxData), .rx_err(rxErr),
      .bus_data(busData), .bus_oe(busOe), .bus_strobe(busStrobe), .bus_ack(busAck)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // scoreboard side: every strobe and every rx_valid must consume a queued expectation
   always @(negedge clock) begin
      if (resetN) begin
         if (busStrobe) begin
            if (wrQ.size() == 0) checkOutput("strobe_unexpected", 1, 0);
            else begin
               monExp = wrQ.pop_front();
               checkOutput("strobe_data", busData, monExp);
            end
            checkOutput("strobe_with_oe", busOe, 1);
         end
         if (rxValid) begin
            if (rdQ.size() == 0) checkOutput("rx_valid_unexpected", 1, 0);
            else begin
               monExp = rdQ.pop_front();
               checkOutput("rx_data", rxData, monExp);
            end
         end
         if (peerOe && busOe) checkOutput("bus_contention", busOe, 0);
      end
   end

   task automatic applyStimulus(input bit wr, input bit rd, input logic [W-1:0] data);
      @(negedge clock);
      txValid = wr;
      rxReq   = rd;
      txData  = data;
      #1;
      if (wr) begin
         checkOutput("tx_ready", txReady, 1);
         wrQ.push_back(data);
      end else if (rd) begin
         checkOutput("rx_ready", rxReady, 1);
      end
      @(posedge clock);
      #1;
      txValid = 1'b0;
      rxReq   = 1'b0;
   endtask

   task automatic issueWrite(input logic [W-1:0] data);
      bit turn;
      turn = !expDir;
      applyStimulus(1'b1, 1'b0, data);
      if (turn) begin
         repeat (TURN) begin
            @(negedge clock);
            checkOutput("wr_turn_oe", busOe, 0);
            checkOutput("wr_turn_strobe", busStrobe, 0);
         end
      end
      @(negedge clock);
      checkOutput("wr_strobe", busStrobe, 1);
      checkOutput("wr_oe", busOe, 1);
      expDir = 1'b1;
      @(negedge clock);
      checkOutput("wr_park_oe", busOe, 1);
      checkOutput("wr_strobe_end", busStrobe, 0);
   endtask

   // Called at the start of the cycle after read acceptance; pre = cycles before the ack cycle.
   task automatic finishRead(input logic [W-1:0] data, input int pre);
      for (int i = 0; i < pre; i++) begin
         @(negedge clock);
         checkOutput("rd_released_oe", busOe, 0);
         checkOutput("rd_no_early_valid", rxValid, 0);
         @(posedge clock);
         #1;
      end
      peerOe   = 1'b1;
      peerData = data;
      busAck   = 1'b1;
      rdQ.push_back(data);
      lastRx = data;
      @(negedge clock);
      checkOutput("rd_ack_oe", busOe, 0);
      @(posedge clock);
      #1;
      peerOe = 1'b0;
      busAck = 1'b0;
      @(negedge clock);
      checkOutput("rd_valid", rxValid, 1);
      checkOutput("rd_err", rxErr, 0);
      expDir = 1'b0;
      @(negedge clock);
      checkOutput("rd_valid_pulse", rxValid, 0);
   endtask

   task automatic issueRead(input logic [W-1:0] data, input int ackDelay);
      int pre;
      pre = (expDir ? TURN : 0) + ackDelay;
      applyStimulus(1'b0, 1'b1, '0);
      finishRead(data, pre);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $display("Result: errors=%0d of %0d checks", errCount + 1, checkCount + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      resetN = 1'b0; txValid = 1'b0; txData = '0; rxReq = 1'b0;
      busAck = 1'b0; peerOe = 1'b0; peerData = '0; expDir = 1'b0; lastRx = '0;
      repeat (3) @(negedge clock);
      checkOutput("rst_oe", busOe, 0);
      checkOutput("rst_strobe", busStrobe, 0);
      checkOutput("rst_rx_valid", rxValid, 0);
      checkOutput("rst_rx_err", rxErr, 0);
      checkOutput("rst_rx_data", rxData, 0);
      checkOutput("rst_tx_ready", txReady, 1);
      checkOutput("rst_rx_ready", rxReady, 1);
      resetN = 1'b1;

      $display("[TB] write after reset pays turnaround");
      issueWrite(8'hA5);

      $display("[TB] back-to-back writes");
      @(negedge clock);
      txValid = 1'b1; txData = 8'h11; wrQ.push_back(8'h11);
      #1 checkOutput("b2b_ready0", txReady, 1);
      @(posedge clock);
      #1 txData = 8'h22; wrQ.push_back(8'h22);
      @(negedge clock);
      checkOutput("b2b_strobe0", busStrobe, 1);
      checkOutput("b2b_busy", txReady, 0);
      strobeCyc = cyc;
      @(negedge clock);
      checkOutput("b2b_ready1", txReady, 1);
      @(posedge clock);
      #1 txValid = 1'b0;
      @(negedge clock);
      checkOutput("b2b_strobe1", busStrobe, 1);
      checkOutput("b2b_spacing", cyc - strobeCyc, 2);

      $display("[TB] bus_ack outside a read is ignored");
      @(negedge clock);
      busAck = 1'b1;
      @(negedge clock);
      busAck = 1'b0;
      checkOutput("ack_ignored", rxValid, 0);
      @(negedge clock);
      checkOutput("ack_ignored_late", rxValid, 0);
      checkOutput("ack_ignored_oe", busOe, 1);

      $display("[TB] read after write with turnaround");
      issueRead(8'h3C, 2);

      $display("[TB] simultaneous write and read");
      @(negedge clock);
      txValid = 1'b1; txData = 8'h77; rxReq = 1'b1; wrQ.push_back(8'h77);
      #1;
      checkOutput("prio_tx_ready", txReady, 1);
      checkOutput("prio_rx_ready", rxReady, 0);
      @(posedge clock);
      #1 txValid = 1'b0;
      repeat (TURN) begin
         @(negedge clock);
         checkOutput("prio_turn_oe", busOe, 0);
         checkOutput("prio_turn_rx_ready", rxReady, 0);
      end
      @(negedge clock);
      checkOutput("prio_strobe", busStrobe, 1);
      checkOutput("prio_drive_rx_ready", rxReady, 0);
      expDir = 1'b1;
      @(negedge clock);
      checkOutput("prio_rd_accept", rxReady, 1);
      @(posedge clock);
      #1 rxReq = 1'b0;
      finishRead(8'h5A, TURN);

      $display("[TB] reset during WAIT");
      applyStimulus(1'b0, 1'b1, '0);
      @(negedge clock);
      checkOutput("wait_oe", busOe, 0);
      #2 resetN = 1'b0;
      #1;
      checkOutput("rstw_oe", busOe, 0);
      checkOutput("rstw_rx_data", rxData, 0);
      checkOutput("rstw_rx_valid", rxValid, 0);
      checkOutput("rstw_tx_ready", txReady, 1);
      expDir = 1'b0; lastRx = '0;
      @(negedge clock);
      resetN = 1'b1;
      issueWrite(8'h5E);

      $display("[TB] reset during DRIVE");
      applyStimulus(1'b1, 1'b0, 8'hC3);
      @(negedge clock);
      checkOutput("drv_strobe", busStrobe, 1);
      checkOutput("drv_oe", busOe, 1);
      #2 resetN = 1'b0;
      #1;
      checkOutput("rstd_oe", busOe, 0);
      checkOutput("rstd_strobe", busStrobe, 0);
      checkOutput("rstd_rx_err", rxErr, 0);
      expDir = 1'b0;
      @(negedge clock);
      resetN = 1'b1;
      issueWrite(8'h96);

      issueRead(8'h42, 1);
      checkOutput("last_rx_data", rxData, lastRx);

`ifdef TRISTATE_BUS_TIMEOUT_EN
      $display("[TB] read timeout");
      issueWrite(8'h0F);
      applyStimulus(1'b0, 1'b1, '0);
      for (int i = 0; i < TURN + TIMEOUT; i++) begin
         @(negedge clock);
         checkOutput("to_no_err_yet", rxErr, 0);
         checkOutput("to_oe", busOe, 0);
      end
      @(negedge clock);
      checkOutput("to_err", rxErr, 1);
      checkOutput("to_no_valid", rxValid, 0);
      checkOutput("to_rx_hold", rxData, lastRx);
      checkOutput("to_idle", txReady, 1);
      expDir = 1'b0;
      @(negedge clock);
      checkOutput("to_err_pulse", rxErr, 0);
      issueRead(8'h99, 0);
`else
      checkOutput("no_timeout_err", rxErr, 0);
`endif

      repeat (2) @(negedge clock);
      checkOutput("wrq_drained", wrQ.size(), 0);
      checkOutput("rdq_drained", rdQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
